// File: rtl/shift_add_mult.sv
// ---------------------------------------------------------------------------
// shift_add_mult
//   Multi-cycle shift-and-add multiplier with an integrated datapath and
//   control FSM. It sits beside the ALU as the MUL unit.
//
//   The operation runs on operand magnitudes. The sign is fixed up in a
//   single FIX cycle at the end. The loop stops early once the remaining
//   multiplier bits are all zero, so short multipliers finish quickly.
//
// Parameters
//   SIZE   operand width; prod is 2*SIZE bits (SIZE >= 2)
//   CNT_W  iteration-counter width (2**CNT_W > SIZE)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   start        request, sampled only while idle
//   signed_mode  1: a/b are two's complement, 0: unsigned (sampled with start)
//   a            multiplicand (sampled with start)
//   b            multiplier (sampled with start)
//   prod         result register; holds until the next accepted start
//   busy         high while the job is in RUN or FIX
//   done         one-cycle pulse; prod is valid while it is high
// ---------------------------------------------------------------------------
module shift_add_mult #(
   parameter int SIZE  = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              signed_mode,
   input  logic [SIZE-1:0]   a,
   input  logic [SIZE-1:0]   b,
   output logic [2*SIZE-1:0] prod,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [2*SIZE-1:0] PROD_ONE = {{(2*SIZE-1){1'b0}}, 1'b1};
   localparam logic [SIZE-1:0]   OPND_ONE = {{(SIZE-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SIZE - 1);

   // Absolute value of an operand, read as unsigned.
   // For the most negative value, negating in SIZE bits gives the pattern
   // 1000...0. Read as unsigned, that pattern is exactly 2**(SIZE-1), so it
   // does not overflow.
   function automatic logic [SIZE-1:0] magnitude(input logic [SIZE-1:0] v,
                                                 input logic            sgn);
      if (sgn && v[SIZE-1]) begin
         magnitude = ~v + OPND_ONE;
      end else begin
         magnitude = v;
      end
   endfunction

   state_t              state_r;
   logic [2*SIZE-1:0]   a_r;       // shifted multiplicand magnitude
   logic [SIZE-1:0]     b_r;       // remaining multiplier magnitude bits
   logic [CNT_W-1:0]    cnt_r;
   logic                neg_r;     // final result must be negated

   logic [2*SIZE-1:0]   addend_s;
   logic [2*SIZE-1:0]   sum_s;
   logic [SIZE-1:0]     b_next_s;
   logic                last_s;

   // Datapath for one RUN step, plus the early-exit / iteration-limit test
   always_comb begin
      addend_s = '0;
      if (b_r[0]) begin
         addend_s = a_r;
      end else begin
         addend_s = '0;
      end
      sum_s    = prod + addend_s;
      b_next_s = b_r >> 1;
      last_s   = (b_next_s == '0) || (cnt_r == CNT_LAST);
   end

   // Control FSM with the registered datapath and handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         cnt_r   <= '0;
         neg_r   <= 1'b0;
         prod    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= {{SIZE{1'b0}}, magnitude(a, signed_mode)};
                  b_r     <= magnitude(b, signed_mode);
                  prod    <= '0;
                  cnt_r   <= '0;
                  neg_r   <= signed_mode & (a[SIZE-1] ^ b[SIZE-1]);
                  busy    <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               prod  <= sum_s;
               a_r   <= a_r << 1;
               b_r   <= b_next_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (last_s) begin
                  state_r <= FIX;
               end else begin
                  state_r <= RUN;
               end
            end
            FIX: begin
               // A zero product stays zero under negation, so neg needs no
               // special case for b == 0.
               if (neg_r) begin
                  prod <= ~prod + PROD_ONE;
               end else begin
                  prod <= prod;
               end
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        signed_mode;
   logic [31:0] a;
   logic [31:0] b;
   logic [63:0] prod;
   logic        busy;
   logic        done;

   int total  = 0;
   int passed = 0;

   shift_add_mult #(.SIZE(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .prod(prod), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      int          k;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: exact product from plain integer arithmetic
   function automatic logic [63:0] ref_prod(input logic m, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      sx = m ? longint'($signed(x)) : longint'({32'd0, x});
      sy = m ? longint'($signed(y)) : longint'({32'd0, y});
      return 64'(sx * sy);
   endfunction

   // Reference: RUN-cycle count from the bit length of |y|
   function automatic int ref_k(input logic m, input logic [31:0] y);
      longint sy;
      longint my;
      int     len;
      sy  = m ? longint'($signed(y)) : longint'({32'd0, y});
      my  = (sy < 0) ? -sy : sy;
      len = 0;
      for (int i = 0; i < 33; i++) if (my[i]) len = i + 1;
      return (len < 1) ? 1 : len;
   endfunction

   // Present a request and let the start edge (edge 0) sample it
   task automatic launch(input logic m, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; signed_mode = m; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Count edges after edge 0 until done is seen; bounded
   task automatic wait_done(output int edges, output int busy_cnt);
      edges = 0; busy_cnt = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         edges++;
      end
      if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
   endtask

   initial begin
      int          edges, bcnt;
      logic        m;
      logic [31:0] x, y;
      logic [63:0] held;

      tbl[0] = '{1'b0, 32'd3,          32'd5,          64'd15,                  3};
      tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd6,          64'hFFFFFFFFFFFFFFD6,    3};
      tbl[2] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001,   32};
      tbl[3] = '{1'b1, 32'h80000000,   32'h80000000,   64'h4000000000000000,   32};
      tbl[4] = '{1'b0, 32'd123,        32'd0,          64'd0,                   1};
      tbl[5] = '{1'b1, 32'd5,          32'hFFFFFFFF,   64'hFFFFFFFFFFFFFFFB,    1};

      reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = 32'd0; b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_prod", prod, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      @(negedge clk); reset = 1'b0;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         launch(tbl[i].m, tbl[i].a, tbl[i].b);
         wait_done(edges, bcnt);
         chk($sformatf("tbl%0d_prod", i), prod, tbl[i].p);
         chk($sformatf("tbl%0d_latency", i), 64'(edges), 64'(tbl[i].k + 1));
         chk($sformatf("tbl%0d_busy", i), 64'(bcnt), 64'(tbl[i].k + 1));
         held = prod;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_done_pulse", i), {63'd0, done}, 64'd0);
         chk($sformatf("tbl%0d_hold", i), prod, held);
      end

      // Randomised jobs against the reference model
      for (int i = 0; i < 30; i++) begin
         m = 1'($urandom_range(0, 1));
         x = $urandom;
         y = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) y = ~y;
         launch(m, x, y);
         wait_done(edges, bcnt);
         chk($sformatf("rnd%0d_prod m=%0d a=%h b=%h", i, m, x, y), prod, ref_prod(m, x, y));
         chk($sformatf("rnd%0d_latency", i), 64'(edges), 64'(ref_k(m, y) + 1));
      end

      // Start while busy is ignored
      launch(1'b0, 32'd9, 32'd9);
      @(negedge clk);
      start = 1'b1; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(edges, bcnt);
      chk("busy_start_prod", prod, 64'd81);
      chk("busy_start_latency", 64'(edges + 1), 64'd5);
      repeat (2) @(posedge clk);
      #1;
      chk("busy_start_no_rerun", {63'd0, busy}, 64'd0);

      // Reset in the middle of a run takes effect at once
      launch(1'b0, 32'd5, 32'hFF);
      @(posedge clk); #1;
      chk("pre_reset_prod", prod, 64'd5);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrun_reset_prod", prod, 64'd0);
      chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
      chk("midrun_reset_done", {63'd0, done}, 64'd0);
      @(negedge clk); reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("post_reset_idle", {63'd0, busy}, 64'd0);

      // Back-to-back: next start accepted in the done cycle
      launch(1'b0, 32'd2, 32'd3);
      wait_done(edges, bcnt);
      chk("b2b_first_prod", prod, 64'd6);
      chk("b2b_first_latency", 64'(edges), 64'd3);
      start = 1'b1; signed_mode = 1'b0; a = 32'd4; b = 32'd5;
      #2;
      chk("b2b_prod_held", prod, 64'd6);
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_no_dead_cycle", {63'd0, busy}, 64'd1);
      chk("b2b_prod_cleared", prod, 64'd0);
      wait_done(edges, bcnt);
      chk("b2b_second_prod", prod, 64'd20);
      chk("b2b_second_latency", 64'(edges), 64'd4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
